// File: rtl/altufm_osc_pkg.sv
// Shared types and default constants for the altufm_osc oscillator block.
package altufm_osc_pkg;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_STARTUP,
        ST_RUN,
        ST_STOP
    } osc_state_e;

    localparam int HALF_PERIOD_DEF   = 4;
    localparam int STARTUP_EDGES_DEF = 4;

endpackage

// File: rtl/altufm_osc.sv
// Glitch-free gated oscillator: divides clk into a 50% duty osc with a
// startup rise count before osc_valid, and a clean stop at the end of a high phase.
module altufm_osc
    import altufm_osc_pkg::*;
#(
    parameter int HALF_PERIOD   = HALF_PERIOD_DEF,
    parameter int STARTUP_EDGES = STARTUP_EDGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic oscena,
    output logic osc,
    output logic osc_rise,
    output logic osc_valid
);

    localparam int PH_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int ED_W = (STARTUP_EDGES > 1) ? $clog2(STARTUP_EDGES) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF_PERIOD - 1);
    localparam logic [ED_W-1:0] ED_LAST = ED_W'((STARTUP_EDGES > 0) ? STARTUP_EDGES - 1 : 0);

    generate
        if (HALF_PERIOD < 1) begin : g_bad_half_period
            $error("altufm_osc: HALF_PERIOD must be at least 1");
        end
    endgenerate

    osc_state_e      state_q, state_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [ED_W-1:0] edges_q, edges_d;
    logic            osc_q, osc_d;
    logic            rise_q, rise_d;
    logic            valid_q, valid_d;

    logic term;
    logic rise_now;

    assign term     = (phase_q == PH_LAST);
    assign rise_now = term && !osc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_OFF;
            phase_q <= '0;
            edges_q <= '0;
            osc_q   <= 1'b0;
            rise_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            edges_q <= edges_d;
            osc_q   <= osc_d;
            rise_q  <= rise_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_OFF: begin
                if (oscena) state_d = (STARTUP_EDGES == 0) ? ST_RUN : ST_STARTUP;
            end
            ST_STARTUP, ST_RUN: begin
                // A high phase ending on this very edge needs no STOP detour.
                if (!oscena) begin
                    state_d = (osc_q && !term) ? ST_STOP : ST_OFF;
                end else if (state_q == ST_STARTUP && rise_now && edges_q == ED_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_STOP: begin
                if (term) state_d = ST_OFF;
            end
            default: state_d = ST_OFF;
        endcase
    end

    always_comb begin
        phase_d = '0;
        edges_d = '0;
        osc_d   = 1'b0;
        rise_d  = 1'b0;
        valid_d = (state_d == ST_RUN);
        if (state_q != ST_OFF && state_d != ST_OFF) begin
            phase_d = term ? '0 : phase_q + 1'b1;
            osc_d   = osc_q ^ term;
            rise_d  = rise_now;
            edges_d = (state_q == ST_STARTUP && state_d == ST_STARTUP && rise_now)
                      ? edges_q + 1'b1 : edges_q;
        end
    end

    assign osc       = osc_q;
    assign osc_rise  = rise_q;
    assign osc_valid = valid_q;

endmodule

// File: tb/tb_altufm_osc.sv
// Directed bench for altufm_osc: default-style instance (4/2) and a minimal
// instance (1/0), edges numbered from the first edge sampling oscena=1.
module tb_altufm_osc;

    logic clk;
    logic rst_a, ena_a, osc_a, rise_a, valid_a;
    logic rst_b, ena_b, osc_b, rise_b, valid_b;

    int unsigned n_checks;
    int unsigned n_errors;

    altufm_osc #(.HALF_PERIOD(4), .STARTUP_EDGES(2)) u_dut_a (
        .clk      (clk),
        .rst      (rst_a),
        .oscena   (ena_a),
        .osc      (osc_a),
        .osc_rise (rise_a),
        .osc_valid(valid_a)
    );

    altufm_osc #(.HALF_PERIOD(1), .STARTUP_EDGES(0)) u_dut_b (
        .clk      (clk),
        .rst      (rst_b),
        .oscena   (ena_b),
        .osc      (osc_b),
        .osc_rise (rise_b),
        .osc_valid(valid_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string sc, input int e, input logic eo, input logic er, input logic ev);
        chk($sformatf("%s_osc@%0d", sc, e), osc_a, eo);
        chk($sformatf("%s_rise@%0d", sc, e), rise_a, er);
        chk($sformatf("%s_valid@%0d", sc, e), valid_a, ev);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_a = 1'b1;
        ena_a = 1'b1;
        rst_b = 1'b1;
        ena_b = 1'b0;

        // Reset dominates an asserted enable.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_a("rst", i, 1'b0, 1'b0, 1'b0);
        end

        // Start, two rises to valid, drop enable mid high phase.
        rst_a = 1'b0;
        for (int e = 0; e <= 20; e++) begin
            ena_a = (e < 14);
            tick();
            chk_a("run", e, (e >= 4 && e <= 7) || (e >= 12 && e <= 15),
                  e == 4 || e == 12, e == 12 || e == 13);
        end

        // Enable dropped while osc is low: immediate stop, never valid.
        for (int e = 0; e <= 16; e++) begin
            ena_a = (e < 9);
            tick();
            chk_a("lowstop", e, e >= 4 && e <= 7, e == 4, 1'b0);
        end

        // Reset in RUN, then a fresh start after release.
        for (int e = 0; e <= 25; e++) begin
            ena_a = (e < 14) || (e >= 20);
            rst_a = (e == 13);
            tick();
            chk_a("rstrun", e, (e >= 4 && e <= 7) || e == 12 || e >= 24,
                  e == 4 || e == 12 || e == 24, e == 12);
        end

        rst_a = 1'b1;
        tick();
        chk_a("rst2", 0, 1'b0, 1'b0, 1'b0);
        rst_a = 1'b0;

        // Enable low for one edge only: STOP ignores it, then full restart at 17.
        for (int e = 0; e <= 30; e++) begin
            ena_a = (e != 14);
            tick();
            chk_a("restart", e,
                  (e >= 4 && e <= 7) || (e >= 12 && e <= 15) || (e >= 21 && e <= 24) || e >= 29,
                  e == 4 || e == 12 || e == 21 || e == 29,
                  e == 12 || e == 13 || e >= 29);
        end

        // HALF_PERIOD=1, STARTUP_EDGES=0: valid at once, toggling every edge.
        rst_b = 1'b0;
        for (int e = 0; e <= 9; e++) begin
            ena_b = (e < 8);
            tick();
            chk($sformatf("min_osc@%0d", e), osc_b, (e < 8) && (e % 2 == 1));
            chk($sformatf("min_rise@%0d", e), rise_b, (e < 8) && (e % 2 == 1));
            chk($sformatf("min_valid@%0d", e), valid_b, e < 8);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/altufm_osc.md
ALTUFM_OSC -- requirements
Module: altufm_osc

Interface
REQ-001 Parameter HALF_PERIOD, default 4: clk cycles per osc half-period; value below 1 SHALL be an elaboration error.
REQ-002 Parameter STARTUP_EDGES, default 4: osc rising edges after enable before osc_valid asserts; 0 allowed.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 oscena  input  1  oscillator enable, sampled each clk edge.
REQ-007 osc  output  1  generated oscillator, registered, 50% duty, period 2*HALF_PERIOD clk cycles.
REQ-008 osc_rise  output  1  one-clk strobe, high in exactly the cycles where osc has just gone 0->1.
REQ-009 osc_valid  output  1  high once the oscillator has completed startup and is enabled.

Function
REQ-010 The block SHALL implement a state machine with states OFF, STARTUP, RUN and STOP.
REQ-011 OFF: osc=0, phase counter=0, edge counter=0, osc_valid=0; oscena sampled 1 -> STARTUP at that edge.
REQ-012 Phase counter SHALL count 0..HALF_PERIOD-1 in STARTUP/RUN/STOP; at terminal count osc toggles and the counter wraps to 0 on the same edge.
REQ-013 First osc rise SHALL occur exactly HALF_PERIOD edges after the edge that moved OFF->STARTUP; each high and low phase SHALL last exactly HALF_PERIOD cycles.
REQ-014 STARTUP SHALL count osc rising edges; on the edge producing rise number STARTUP_EDGES, osc_valid SHALL assert and the state SHALL become RUN; with STARTUP_EDGES=0, OFF SHALL go directly to RUN with osc_valid=1.
REQ-015 osc_rise SHALL assert on the same edge osc goes 0->1 and deassert on the next edge.
REQ-016 oscena sampled 0 in STARTUP/RUN with osc=0: state SHALL go OFF on that edge; osc stays 0; no partial low phase extension.
REQ-017 oscena sampled 0 in STARTUP/RUN with osc=1: state SHALL go STOP; the current high phase completes at full length, then osc->0 and state->OFF on the same edge.
REQ-018 osc_valid SHALL deassert on the edge oscena is sampled 0, regardless of osc level.
REQ-019 oscena is ignored in STOP; if high once OFF is reached, OFF->STARTUP SHALL follow on the next edge with a full startup count.
REQ-020 osc SHALL never produce a high or low pulse shorter than HALF_PERIOD cycles (glitch-free start and stop).
REQ-021 Counter widths SHALL be $clog2 of their maximum values (minimum 1 bit); no overflow possible.

Reset
REQ-022 rst=1 SHALL force state OFF, osc=0, osc_rise=0, osc_valid=0, both counters 0 on the next edge, overriding oscena and any state.
REQ-023 After rst release, behaviour SHALL be identical to power-up OFF.

Structure
REQ-024 Package altufm_osc_pkg SHALL hold the state enum typedef and the default constants for HALF_PERIOD and STARTUP_EDGES.
REQ-025 Single flat module; no sub-module; all outputs driven directly from flops.

Verification (HALF_PERIOD=4, STARTUP_EDGES=2 unless stated)
REQ-026 rst=1, oscena=1 for 3 edges -> osc, osc_rise, osc_valid all 0 throughout.
REQ-027 oscena=1 sampled at edge 0 -> osc rises edges 4,12, falls 8,16; osc_rise only at 4,12; osc_valid 1 from edge 12.
REQ-028 Continuing REQ-027, oscena=0 sampled at edge 14 -> osc_valid 0 at edge 14, osc falls at 16, stays 0; no further osc_rise.
REQ-029 oscena=0 sampled at edge 9 (osc low) -> state OFF at 9, osc remains 0, osc_valid never asserted.
REQ-030 rst asserted at edge 13 in RUN -> all outputs 0 at 13; oscena=1 sampled at edge 20 after release -> next rise at edge 24.
REQ-031 HALF_PERIOD=1, STARTUP_EDGES=0 -> osc toggles every edge from edge 1, osc_valid 1 from edge 0.
